// File: rtl/ysyx_25030093_pkg.sv
// Shared core definitions for the ysyx_25030093 pipeline (IFU/IDU/EXU).
// Holds the fetch state encoding, the reset PC, the nop word and the AXI response codes.
package ysyx_25030093_pkg;

    typedef enum logic [2:0] {
        IFU_IDLE,
        IFU_ADDR,
        IFU_DATA,
        IFU_SEND,
        IFU_WAIT_NPC
    } ifu_state_e;

    localparam logic [31:0] RESET_PC   = 32'h8000_0000;
    localparam logic [31:0] INST_NOP   = 32'h0000_0013;
    localparam logic [1:0]  RRESP_OKAY = 2'b00;

    function automatic logic pc_aligned(input logic [31:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/ysyx_25030093_ifu.sv
// Instruction fetch unit: one AXI4-Lite read per instruction, handshakes the word to
// decode, then waits for the next PC from write-back before fetching again.
module ysyx_25030093_ifu
    import ysyx_25030093_pkg::*;
#(
    parameter logic [31:0] RESET_PC = ysyx_25030093_pkg::RESET_PC
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic [31:0] npc,
    input  logic        npc_valid,
    output logic        npc_ready,
    output logic        fetch_fault
);

    ifu_state_e  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic        r_arvalid;
    logic        r_rready;
    logic        r_inst_valid;
    logic        r_npc_ready;
    logic        r_fetch_fault;

    // Handshake outputs are registered alongside the state; the ADDR-entry alignment test
    // decides up front whether the AR request goes out or the fault pulse fires instead.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= IFU_IDLE;
            r_pc          <= RESET_PC;
            r_inst        <= INST_NOP;
            r_arvalid     <= 1'b0;
            r_rready      <= 1'b0;
            r_inst_valid  <= 1'b0;
            r_npc_ready   <= 1'b0;
            r_fetch_fault <= 1'b0;
        end else begin
            r_fetch_fault <= 1'b0;
            case (r_state)
                IFU_IDLE: begin
                    r_state       <= IFU_ADDR;
                    r_arvalid     <= pc_aligned(r_pc);
                    r_fetch_fault <= !pc_aligned(r_pc);
                end
                IFU_ADDR: begin
                    if (!r_arvalid) begin
                        r_state     <= IFU_WAIT_NPC;
                        r_npc_ready <= 1'b1;
                    end else if (arready) begin
                        r_state   <= IFU_DATA;
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                    end
                end
                IFU_DATA: begin
                    if (rvalid) begin
                        r_rready <= 1'b0;
                        if (rresp == RRESP_OKAY) begin
                            r_inst       <= rdata;
                            r_state      <= IFU_SEND;
                            r_inst_valid <= 1'b1;
                        end else begin
                            r_fetch_fault <= 1'b1;
                            r_state       <= IFU_WAIT_NPC;
                            r_npc_ready   <= 1'b1;
                        end
                    end
                end
                IFU_SEND: begin
                    if (inst_ready) begin
                        r_inst_valid <= 1'b0;
                        r_state      <= IFU_WAIT_NPC;
                        r_npc_ready  <= 1'b1;
                    end
                end
                IFU_WAIT_NPC: begin
                    if (npc_valid) begin
                        r_npc_ready   <= 1'b0;
                        r_pc          <= npc;
                        r_state       <= IFU_ADDR;
                        r_arvalid     <= pc_aligned(npc);
                        r_fetch_fault <= !pc_aligned(npc);
                    end
                end
                default: begin
                    r_state      <= IFU_IDLE;
                    r_arvalid    <= 1'b0;
                    r_rready     <= 1'b0;
                    r_inst_valid <= 1'b0;
                    r_npc_ready  <= 1'b0;
                end
            endcase
        end
    end

    assign araddr      = r_pc;
    assign arvalid     = r_arvalid;
    assign rready      = r_rready;
    assign inst        = r_inst;
    assign pc          = r_pc;
    assign inst_valid  = r_inst_valid;
    assign npc_ready   = r_npc_ready;
    assign fetch_fault = r_fetch_fault;

endmodule

// File: tb/tb_ysyx_25030093_ifu.sv
// Directed bench for the fetch unit: a per-cycle vector table plus latency sequences
// with stalls inserted on every handshake.
module tb_ysyx_25030093_ifu;

    logic        clock;
    logic        reset;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] npc;
    logic        npc_valid;
    logic        npc_ready;
    logic        fetch_fault;

    int unsigned n_cmp;
    int unsigned n_fail;

    ysyx_25030093_ifu #(.RESET_PC(32'h8000_0000)) dut (
        .clock      (clock),
        .reset      (reset),
        .araddr     (araddr),
        .arvalid    (arvalid),
        .arready    (arready),
        .rdata      (rdata),
        .rresp      (rresp),
        .rvalid     (rvalid),
        .rready     (rready),
        .inst       (inst),
        .pc         (pc),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .npc        (npc),
        .npc_valid  (npc_valid),
        .npc_ready  (npc_ready),
        .fetch_fault(fetch_fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Expected phase after the edge; handshake outputs follow from it.
    typedef enum logic [2:0] {T_IDLE, T_ADDR, T_ADDRF, T_DATA, T_SEND, T_WAIT} tag_e;

    typedef struct {
        logic        rst;
        logic        arr;
        logic        rv;
        logic [1:0]  rr;
        logic [31:0] rd;
        logic        ir;
        logic        nv;
        logic [31:0] np;
        tag_e        t;
        logic [31:0] epc;
        logic [31:0] einst;
        logic        ef;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic arr, logic rv, logic [1:0] rr, logic [31:0] rd,
                                logic ir, logic nv, logic [31:0] np,
                                tag_e t, logic [31:0] epc, logic [31:0] einst, logic ef);
        vec_t v;
        v.rst = rst; v.arr = arr; v.rv = rv; v.rr = rr; v.rd = rd;
        v.ir = ir; v.nv = nv; v.np = np;
        v.t = t; v.epc = epc; v.einst = einst; v.ef = ef;
        return v;
    endfunction

    task automatic check(input string name, input logic [103:0] act, input logic [103:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        arready = 1'b0; rvalid = 1'b0; rresp = 2'b00; rdata = '0;
        inst_ready = 1'b0; npc_valid = 1'b0; npc = '0;
    endtask

    // Starts with arvalid high; drives each handshake after the given stall and checks
    // the fetch-to-fetch distance is 4 cycles plus the stalls.
    task automatic fetch(input int unsigned s_ar, input int unsigned s_r, input int unsigned s_i,
                         input int unsigned s_n, input logic [31:0] word, input logic [31:0] nxt);
        int unsigned cyc;
        logic [31:0] cur;
        cyc = 0;
        cur = pc;
        for (int unsigned k = 0; k < s_ar; k++) begin
            idle_inputs(); step(); cyc++;
        end
        idle_inputs(); arready = 1'b1; step(); cyc++;
        check("seq_data", {103'd0, rready}, {103'd0, 1'b1});
        for (int unsigned k = 0; k < s_r; k++) begin
            idle_inputs(); step(); cyc++;
        end
        idle_inputs(); rvalid = 1'b1; rdata = word; step(); cyc++;
        check("seq_send", {39'd0, inst_valid, pc, inst}, {39'd0, 1'b1, cur, word});
        for (int unsigned k = 0; k < s_i; k++) begin
            idle_inputs(); step(); cyc++;
        end
        idle_inputs(); inst_ready = 1'b1; step(); cyc++;
        check("seq_wait", {103'd0, npc_ready}, {103'd0, 1'b1});
        for (int unsigned k = 0; k < s_n; k++) begin
            idle_inputs(); step(); cyc++;
        end
        idle_inputs(); npc_valid = 1'b1; npc = nxt; step(); cyc++;
        idle_inputs();
        check("seq_addr", {71'd0, arvalid, araddr}, {71'd0, 1'b1, nxt});
        check("seq_latency", 104'(cyc), 104'(4 + s_ar + s_r + s_i + s_n));
    endtask

    initial begin
        logic [31:0] P0, W1, W2, W3, NOPW;
        vec_t v;
        logic [103:0] act, exp;
        logic e_arv, e_rr, e_iv, e_nr;

        n_cmp = 0;
        n_fail = 0;
        P0 = 32'h8000_0000; W1 = 32'h0010_0093; W2 = 32'h00A0_0113; W3 = 32'h0000_0517;
        NOPW = 32'h0000_0013;
        reset = 1'b1;
        idle_inputs();

        //                 rst arr rv rr     rdata          ir nv npc            tag      pc             inst  flt
        vecs.push_back(mk(1, 0, 0, 2'b00, 32'h0,         0, 0, 32'h0,         T_IDLE,  P0,            NOPW, 0));
        vecs.push_back(mk(0, 0, 0, 2'b00, 32'h0,         0, 0, 32'h0,         T_ADDR,  P0,            NOPW, 0));
        vecs.push_back(mk(0, 1, 0, 2'b00, 32'h0,         0, 0, 32'h0,         T_DATA,  P0,            NOPW, 0));
        vecs.push_back(mk(0, 0, 1, 2'b00, W1,            0, 0, 32'h0,         T_SEND,  P0,            W1,   0));
        vecs.push_back(mk(0, 0, 0, 2'b00, 32'h0,         1, 0, 32'h0,         T_WAIT,  P0,            W1,   0));
        vecs.push_back(mk(0, 0, 0, 2'b00, 32'h0,         0, 1, 32'h8000_0004, T_ADDR,  32'h8000_0004, W1,  0));
        vecs.push_back(mk(1, 0, 0, 2'b00, 32'h0,         0, 0, 32'h0,         T_IDLE,  P0,            NOPW, 0));
        vecs.push_back(mk(0, 0, 0, 2'b00, 32'h0,         0, 0, 32'h0,         T_ADDR,  P0,            NOPW, 0));
        for (int unsigned k = 0; k < 5; k++)
            vecs.push_back(mk(0, 0, 1, 2'b00, 32'hFFFF_FFFF, 0, 0, 32'h0,     T_ADDR,  P0,            NOPW, 0));
        vecs.push_back(mk(0, 1, 0, 2'b00, 32'h0,         0, 0, 32'h0,         T_DATA,  P0,            NOPW, 0));
        vecs.push_back(mk(0, 0, 0, 2'b00, 32'h0,         0, 0, 32'h0,         T_DATA,  P0,            NOPW, 0));
        vecs.push_back(mk(0, 0, 1, 2'b00, W2,            0, 0, 32'h0,         T_SEND,  P0,            W2,   0));
        for (int unsigned k = 0; k < 3; k++)
            vecs.push_back(mk(0, 0, 0, 2'b00, 32'h0,     0, 1, 32'h1234_5678, T_SEND,  P0,            W2,   0));
        vecs.push_back(mk(0, 0, 0, 2'b00, 32'h0,         1, 0, 32'h0,         T_WAIT,  P0,            W2,   0));
        vecs.push_back(mk(0, 0, 0, 2'b00, 32'h0,         0, 1, 32'h8000_0102, T_ADDRF, 32'h8000_0102, W2,  1));
        vecs.push_back(mk(0, 1, 0, 2'b00, 32'h0,         0, 0, 32'h0,         T_WAIT,  32'h8000_0102, W2,  0));
        vecs.push_back(mk(0, 0, 0, 2'b00, 32'h0,         0, 0, 32'h0,         T_WAIT,  32'h8000_0102, W2,  0));
        vecs.push_back(mk(0, 0, 0, 2'b00, 32'h0,         0, 1, 32'h8000_0008, T_ADDR,  32'h8000_0008, W2,  0));
        vecs.push_back(mk(0, 1, 0, 2'b00, 32'h0,         0, 0, 32'h0,         T_DATA,  32'h8000_0008, W2,  0));
        vecs.push_back(mk(0, 0, 1, 2'b10, 32'hDEAD_BEEF, 0, 0, 32'h0,         T_WAIT,  32'h8000_0008, W2,  1));
        vecs.push_back(mk(0, 0, 0, 2'b00, 32'h0,         1, 0, 32'h0,         T_WAIT,  32'h8000_0008, W2,  0));
        vecs.push_back(mk(0, 0, 0, 2'b00, 32'h0,         0, 1, 32'h8000_0004, T_ADDR,  32'h8000_0004, W2,  0));
        vecs.push_back(mk(0, 1, 0, 2'b00, 32'h0,         0, 0, 32'h0,         T_DATA,  32'h8000_0004, W2,  0));
        vecs.push_back(mk(1, 0, 0, 2'b00, 32'h0,         0, 0, 32'h0,         T_IDLE,  P0,            NOPW, 0));
        vecs.push_back(mk(0, 0, 1, 2'b00, 32'hFFFF_FFFF, 0, 0, 32'h0,         T_ADDR,  P0,            NOPW, 0));
        vecs.push_back(mk(0, 1, 1, 2'b00, 32'hFFFF_FFFF, 0, 0, 32'h0,         T_DATA,  P0,            NOPW, 0));
        vecs.push_back(mk(0, 0, 1, 2'b00, W3,            0, 0, 32'h0,         T_SEND,  P0,            W3,   0));
        vecs.push_back(mk(0, 0, 0, 2'b00, 32'h0,         1, 0, 32'h0,         T_WAIT,  P0,            W3,   0));
        vecs.push_back(mk(0, 0, 0, 2'b00, 32'h0,         0, 1, 32'hFFFF_FFFC, T_ADDR,  32'hFFFF_FFFC, W3,  0));

        for (int unsigned i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            reset = v.rst; arready = v.arr; rvalid = v.rv; rresp = v.rr; rdata = v.rd;
            inst_ready = v.ir; npc_valid = v.nv; npc = v.np;
            step();
            e_arv = (v.t == T_ADDR);
            e_rr  = (v.t == T_DATA);
            e_iv  = (v.t == T_SEND);
            e_nr  = (v.t == T_WAIT);
            act = {3'd0, arvalid, rready, inst_valid, npc_ready, fetch_fault, pc, inst, araddr};
            exp = {3'd0, e_arv, e_rr, e_iv, e_nr, v.ef, v.epc, v.einst, v.epc};
            check($sformatf("vec%0d", i), act, exp);
        end

        // From ADDR at 0xFFFF_FFFC: stalls on each handshake, pc wraps through npc.
        reset = 1'b0;
        idle_inputs();
        fetch(0, 0, 0, 0, 32'h0000_0093, 32'h0000_0000);
        fetch(2, 1, 3, 1, 32'h0020_0113, 32'h0000_0010);
        fetch(1, 3, 0, 2, 32'h0030_0193, 32'h8000_0020);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish, got running want done");
        $fatal(1, "timeout");
    end

endmodule
